dma_apb_bridge: RTL and testbench

APB completer-facing end of the DMA channel's APB FIFO interface. It accepts write/read commands pushed by the DMA channel, executes them as APB transfers to one of `APB_SVL` slaves, and returns read data through a first-word-fall-through response FIFO. The channel-side ports mirror the channel's `dma2apb`/`apb2dma` signals one-for-one.

---
 rtl/dma_apb_bridge.sv | 246 ++++++++++++++++++++++++
 tb/tb_dma_apb_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_apb_bridge.sv
// dma_apb_bridge
//   APB requester that drains the DMA channel's command FIFO. Each command is
//   {pwrite, psel, paddr, pdata}. It is executed as a SETUP/ACCESS transfer
//   to one of APB_SVL slaves. Read results return through a
//   first-word-fall-through response FIFO.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   i_abort              flush both FIFOs and the sticky error flag
//   i_dma2apb_wvalid     command push; i_apb_pwrite/psel/paddr/pdata carry it
//   o_dma2apb_full       command FIFO full
//   i_apb2dma_rready     response pop
//   o_apb2dma_empty      response FIFO empty
//   o_apb_rdata          response FIFO head
//   o_psel .. o_pwdata   APB requester outputs
//   i_pready, i_prdata,  per-slave completer inputs; slave k's read data is
//   i_pslverr            at i_prdata[k*W +: W]
//   o_slverr             sticky slave-error flag
//
// Build option
//   DMA_APB_BRIDGE_TIMEOUT_EN  forces ACCESS to complete after TIMEOUT_CYCLES
//                              cycles without pready. The forced completion
//                              returns zero read data and sets o_slverr.
//
// state  | meaning
// S_IDLE   | no transfer; pops the command FIFO head when it can be issued
// S_SETUP  | APB setup phase: psel high, penable low
// S_ACCESS | APB access phase: psel and penable high until pready (or timeout)

module dma_apb_bridge #(
  parameter int APB_SVL        = 4,
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 16,
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_abort,
  input  logic                              i_dma2apb_wvalid,
  input  logic                              i_apb_pwrite,
  input  logic [$clog2(APB_SVL)-1:0]        i_apb_psel,
  input  logic [APB_ADDR_WIDTH-1:0]         i_apb_paddr,
  input  logic [APB_DATA_WIDTH-1:0]         i_apb_pdata,
  output logic                              o_dma2apb_full,
  input  logic                              i_apb2dma_rready,
  output logic                              o_apb2dma_empty,
  output logic [APB_DATA_WIDTH-1:0]         o_apb_rdata,
  output logic [APB_SVL-1:0]                o_psel,
  output logic                              o_penable,
  output logic                              o_pwrite,
  output logic [APB_ADDR_WIDTH-1:0]         o_paddr,
  output logic [APB_DATA_WIDTH-1:0]         o_pwdata,
  input  logic [APB_SVL-1:0]                i_pready,
  input  logic [APB_SVL*APB_DATA_WIDTH-1:0] i_prdata,
  input  logic [APB_SVL-1:0]                i_pslverr,
  output logic                              o_slverr
);

  localparam int SEL_W = $clog2(APB_SVL);
  localparam int AW    = APB_ADDR_WIDTH;
  localparam int DW    = APB_DATA_WIDTH;
  localparam int CMD_W = 1 + SEL_W + AW + DW;
  localparam int CPW   = $clog2(CMD_DEPTH);
  localparam int RPW   = $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
  logic [CPW-1:0]   cmd_wr_ptr, cmd_rd_ptr;
  logic [CPW:0]     cmd_cnt;
  logic [CMD_W-1:0] cmd_head;
  logic             cmd_push, cmd_pop;

  logic [DW-1:0]    rsp_mem [RSP_DEPTH];
  logic [RPW-1:0]   rsp_wr_ptr, rsp_rd_ptr;
  logic [RPW:0]     rsp_cnt;
  logic [RPW:0]     rsp_level;
  logic [DW-1:0]    rsp_wdata;
  logic             rsp_push, rsp_pop;

  logic             xfer_write;
  logic [SEL_W-1:0] xfer_sel;
  logic [AW-1:0]    xfer_addr;
  logic [DW-1:0]    xfer_data;
  logic             aborted_q;

  logic             sel_ready, sel_err, timeout_hit, xfer_done, issue_ok;

  assign o_dma2apb_full  = (cmd_cnt == (CPW+1)'(CMD_DEPTH));
  assign o_apb2dma_empty = (rsp_cnt == '0);
  assign o_apb_rdata     = o_apb2dma_empty ? '0 : rsp_mem[rsp_rd_ptr];

  assign cmd_push = i_dma2apb_wvalid && !o_dma2apb_full && !i_abort;
  assign rsp_pop  = i_apb2dma_rready && !o_apb2dma_empty && !i_abort;
  assign cmd_head = cmd_mem[cmd_rd_ptr];

  assign sel_ready = i_pready[xfer_sel];
  assign sel_err   = i_pslverr[xfer_sel];
  assign xfer_done = (state == S_ACCESS) && (sel_ready || timeout_hit);

  // A transfer that was aborted still finishes on the bus, but its result is dropped.
  assign rsp_push  = xfer_done && !xfer_write && !aborted_q && !i_abort;
  assign rsp_wdata = timeout_hit ? '0 : i_prdata[xfer_sel*DW +: DW];

  // A read may issue only when its result is guaranteed a slot. The slot
  // count includes a result being pushed this very cycle.
  assign rsp_level = rsp_cnt + (RPW+1)'(rsp_push);
  assign issue_ok  = (cmd_cnt != '0) && !i_abort &&
                     (cmd_head[CMD_W-1] || (rsp_level < (RPW+1)'(RSP_DEPTH)));

`ifdef DMA_APB_BRIDGE_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES+1) > 8) ? $clog2(TIMEOUT_CYCLES+1) : 8;
  logic [TO_W-1:0] to_cnt;

  // The counter is reloaded in SETUP. It reaches zero in the
  // TIMEOUT_CYCLES-th ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == S_SETUP) begin
      to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
    end else if (state == S_ACCESS && to_cnt != '0) begin
      to_cnt <= to_cnt - TO_W'(1);
    end
  end

  assign timeout_hit = (state == S_ACCESS) && (to_cnt == '0) && !sel_ready;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    case (state)
      S_IDLE: begin
        if (issue_ok) begin
          cmd_pop   = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (xfer_done) begin
          if (issue_ok && !aborted_q) begin
            cmd_pop   = 1'b1;
            state_nxt = S_SETUP;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_write <= 1'b0;
      xfer_sel   <= '0;
      xfer_addr  <= '0;
      xfer_data  <= '0;
    end else if (cmd_pop) begin
      xfer_write <= cmd_head[CMD_W-1];
      xfer_sel   <= cmd_head[AW+DW +: SEL_W];
      xfer_addr  <= cmd_head[DW +: AW];
      xfer_data  <= cmd_head[0 +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else if (xfer_done) begin
      aborted_q <= 1'b0;
    end else if (i_abort && state != S_IDLE) begin
      aborted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_abort) begin
      o_slverr <= 1'b0;
    end else if (xfer_done && (sel_err || timeout_hit)) begin
      o_slverr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= {i_apb_pwrite, i_apb_psel, i_apb_paddr, i_apb_pdata};
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || i_abort) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_cnt    <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CPW'(1);
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CPW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt <= cmd_cnt + (CPW+1)'(1);
        2'b01:   cmd_cnt <= cmd_cnt - (CPW+1)'(1);
        default: cmd_cnt <= cmd_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_abort) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_cnt    <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RPW'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RPW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + (RPW+1)'(1);
        2'b01:   rsp_cnt <= rsp_cnt - (RPW+1)'(1);
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

  // psel/penable are gated by reset so a reset mid-transfer releases the bus at once.
  assign o_psel    = (state != S_IDLE && !reset) ? (APB_SVL'(1) << xfer_sel) : '0;
  assign o_penable = (state == S_ACCESS) && !reset;
  assign o_pwrite  = xfer_write;
  assign o_paddr   = xfer_addr;
  assign o_pwdata  = xfer_data;

endmodule

// File: tb/tb_dma_apb_bridge.sv
module tb_dma_apb_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_abort;
  logic        i_dma2apb_wvalid;
  logic        i_apb_pwrite;
  logic [1:0]  i_apb_psel;
  logic [15:0] i_apb_paddr;
  logic [15:0] i_apb_pdata;
  logic        o_dma2apb_full;
  logic        i_apb2dma_rready;
  logic        o_apb2dma_empty;
  logic [15:0] o_apb_rdata;
  logic [3:0]  o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [15:0] o_paddr;
  logic [15:0] o_pwdata;
  logic [3:0]  i_pready;
  logic [63:0] i_prdata;
  logic [3:0]  i_pslverr;
  logic        o_slverr;

  int tests_run = 0;
  int tests_failed = 0;
  int n_xfers = 0;
  int n_setups = 0;

  typedef struct {
    logic        w;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_t;

  always #5 clk = ~clk;

  dma_apb_bridge dut (
    .clk(clk), .reset(reset), .i_abort(i_abort),
    .i_dma2apb_wvalid(i_dma2apb_wvalid), .i_apb_pwrite(i_apb_pwrite),
    .i_apb_psel(i_apb_psel), .i_apb_paddr(i_apb_paddr), .i_apb_pdata(i_apb_pdata),
    .o_dma2apb_full(o_dma2apb_full), .i_apb2dma_rready(i_apb2dma_rready),
    .o_apb2dma_empty(o_apb2dma_empty), .o_apb_rdata(o_apb_rdata),
    .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
    .o_paddr(o_paddr), .o_pwdata(o_pwdata), .i_pready(i_pready),
    .i_prdata(i_prdata), .i_pslverr(i_pslverr), .o_slverr(o_slverr)
  );

  // Passive bus observer: counts completed transfers and setup phases.
  always @(posedge clk) begin
    if (!reset) begin
      if (o_psel != 4'b0 && o_penable && (o_psel & i_pready) != 4'b0) n_xfers <= n_xfers + 1;
      if (o_psel != 4'b0 && !o_penable) n_setups <= n_setups + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [1:0] sel, input logic [15:0] addr,
                          input logic [15:0] data);
    i_dma2apb_wvalid = 1'b1;
    i_apb_pwrite = w;
    i_apb_psel   = sel;
    i_apb_paddr  = addr;
    i_apb_pdata  = data;
    tick();
    i_dma2apb_wvalid = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++; if (o_psel !== 4'b0) begin tests_failed++; $display("FAIL rst_psel got %h exp 0", o_psel); end
    tests_run++; if (o_penable !== 1'b0) begin tests_failed++; $display("FAIL rst_penable got %b exp 0", o_penable); end
    tests_run++; if (o_pwrite !== 1'b0) begin tests_failed++; $display("FAIL rst_pwrite got %b exp 0", o_pwrite); end
    tests_run++; if (o_paddr !== 16'h0) begin tests_failed++; $display("FAIL rst_paddr got %h exp 0", o_paddr); end
    tests_run++; if (o_pwdata !== 16'h0) begin tests_failed++; $display("FAIL rst_pwdata got %h exp 0", o_pwdata); end
    tests_run++; if (o_dma2apb_full !== 1'b0) begin tests_failed++; $display("FAIL rst_full got %b exp 0", o_dma2apb_full); end
    tests_run++; if (o_apb2dma_empty !== 1'b1) begin tests_failed++; $display("FAIL rst_empty got %b exp 1", o_apb2dma_empty); end
    tests_run++; if (o_apb_rdata !== 16'h0) begin tests_failed++; $display("FAIL rst_rdata got %h exp 0", o_apb_rdata); end
    tests_run++; if (o_slverr !== 1'b0) begin tests_failed++; $display("FAIL rst_slverr got %b exp 0", o_slverr); end
  endtask

  task automatic test_single_write();
    i_pready = 4'hF;
    push_cmd(1'b1, 2'd2, 16'h0010, 16'hBEEF);
    tests_run++; if (o_psel !== 4'b0) begin tests_failed++; $display("FAIL wr_n1_psel got %h exp 0", o_psel); end
    tick();
    tests_run++; if (o_psel !== 4'b0100 || o_penable !== 1'b0) begin tests_failed++; $display("FAIL wr_setup got psel=%h en=%b exp psel=4 en=0", o_psel, o_penable); end
    tests_run++; if (o_paddr !== 16'h0010 || o_pwdata !== 16'hBEEF || o_pwrite !== 1'b1) begin tests_failed++; $display("FAIL wr_fields got a=%h d=%h w=%b exp a=0010 d=BEEF w=1", o_paddr, o_pwdata, o_pwrite); end
    tick();
    tests_run++; if (o_psel !== 4'b0100 || o_penable !== 1'b1) begin tests_failed++; $display("FAIL wr_access got psel=%h en=%b exp psel=4 en=1", o_psel, o_penable); end
    tests_run++; if (o_paddr !== 16'h0010 || o_pwdata !== 16'hBEEF) begin tests_failed++; $display("FAIL wr_stable got a=%h d=%h exp a=0010 d=BEEF", o_paddr, o_pwdata); end
    tick();
    tests_run++; if (o_psel !== 4'b0 || o_apb2dma_empty !== 1'b1) begin tests_failed++; $display("FAIL wr_done got psel=%h empty=%b exp psel=0 empty=1", o_psel, o_apb2dma_empty); end
  endtask

  task automatic test_read_return();
    i_pready = 4'b1101;
    i_prdata = {16'hA003, 16'hA002, 16'h1234, 16'hA000};
    push_cmd(1'b0, 2'd1, 16'h0020, 16'h0000);
    tick();
    tick();
    tests_run++; if (o_psel !== 4'b0010 || o_penable !== 1'b1 || o_pwrite !== 1'b0) begin tests_failed++; $display("FAIL rd_access got psel=%h en=%b w=%b exp psel=2 en=1 w=0", o_psel, o_penable, o_pwrite); end
    tick();
    tick();
    tests_run++; if (o_penable !== 1'b1 || o_apb2dma_empty !== 1'b1) begin tests_failed++; $display("FAIL rd_wait got en=%b empty=%b exp en=1 empty=1", o_penable, o_apb2dma_empty); end
    tick();
    i_pready = 4'hF;
    tests_run++; if (o_apb2dma_empty !== 1'b1) begin tests_failed++; $display("FAIL rd_not_early got empty=%b exp 1", o_apb2dma_empty); end
    tick();
    tests_run++; if (o_apb2dma_empty !== 1'b0 || o_apb_rdata !== 16'h1234) begin tests_failed++; $display("FAIL rd_data got empty=%b data=%h exp empty=0 data=1234", o_apb2dma_empty, o_apb_rdata); end
    tests_run++; if (o_psel !== 4'b0) begin tests_failed++; $display("FAIL rd_idle got psel=%h exp 0", o_psel); end
    i_apb2dma_rready = 1'b1;
    tick();
    i_apb2dma_rready = 1'b0;
    tests_run++; if (o_apb2dma_empty !== 1'b1) begin tests_failed++; $display("FAIL rd_pop got empty=%b exp 1", o_apb2dma_empty); end
  endtask

  task automatic test_slverr();
    i_pready  = 4'hF;
    i_pslverr = 4'b0010;
    push_cmd(1'b1, 2'd1, 16'h0030, 16'h5555);
    tick(); tick(); tick();
    tests_run++; if (o_slverr !== 1'b1) begin tests_failed++; $display("FAIL err_set got %b exp 1", o_slverr); end
    i_pslverr = 4'b0;
    push_cmd(1'b1, 2'd1, 16'h0031, 16'h6666);
    tick(); tick(); tick();
    tests_run++; if (o_slverr !== 1'b1) begin tests_failed++; $display("FAIL err_sticky got %b exp 1", o_slverr); end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    tests_run++; if (o_slverr !== 1'b0) begin tests_failed++; $display("FAIL err_abort_clr got %b exp 0", o_slverr); end
`ifdef DMA_APB_BRIDGE_TIMEOUT_EN
    begin
      int acc;
      acc = 0;
      i_pready = 4'b0;
      i_prdata = {16'hA003, 16'hA002, 16'h1234, 16'hA000};
      push_cmd(1'b0, 2'd0, 16'h0040, 16'h0000);
      for (int i = 0; i < 400; i++) begin
        tick();
        if (o_penable) acc++;
        else if (acc > 0 && o_psel == 4'b0) break;
      end
      tests_run++; if (acc != 255) begin tests_failed++; $display("FAIL to_cycles got %0d exp 255", acc); end
      tests_run++; if (o_apb2dma_empty !== 1'b0 || o_apb_rdata !== 16'h0) begin tests_failed++; $display("FAIL to_data got empty=%b data=%h exp empty=0 data=0", o_apb2dma_empty, o_apb_rdata); end
      tests_run++; if (o_slverr !== 1'b1) begin tests_failed++; $display("FAIL to_slverr got %b exp 1", o_slverr); end
      i_pready = 4'hF;
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
    end
`endif
  endtask

  task automatic test_cmd_full();
    int n0;
    n0 = n_xfers;
    i_pready = 4'b1110;
    i_dma2apb_wvalid = 1'b1;
    i_apb_pwrite = 1'b1;
    i_apb_psel = 2'd0;
    i_apb_pdata = 16'hC0DE;
    for (int i = 0; i < 6; i++) begin
      i_apb_paddr = 16'h0040 + 16'(i);
      if (i == 4) begin
        tests_run++; if (o_dma2apb_full !== 1'b0) begin tests_failed++; $display("FAIL full_early got %b exp 0", o_dma2apb_full); end
      end
      if (i == 5) begin
        tests_run++; if (o_dma2apb_full !== 1'b1) begin tests_failed++; $display("FAIL full_after5 got %b exp 1", o_dma2apb_full); end
      end
      tick();
    end
    i_dma2apb_wvalid = 1'b0;
    tests_run++; if (o_dma2apb_full !== 1'b1) begin tests_failed++; $display("FAIL full_hold got %b exp 1", o_dma2apb_full); end
    tick(); tick();
    tests_run++; if (n_xfers - n0 != 0 || o_penable !== 1'b1) begin tests_failed++; $display("FAIL full_stall got xfers=%0d en=%b exp 0 en=1", n_xfers - n0, o_penable); end
    i_pready = 4'hF;
    for (int i = 0; i < 20; i++) tick();
    tests_run++; if (n_xfers - n0 != 5) begin tests_failed++; $display("FAIL full_count got %0d exp 5", n_xfers - n0); end
    tests_run++; if (o_dma2apb_full !== 1'b0 || o_psel !== 4'b0) begin tests_failed++; $display("FAIL full_drain got full=%b psel=%h exp 0 0", o_dma2apb_full, o_psel); end
  endtask

  task automatic test_abort();
    int nx0, ns0;
    i_pready = 4'hF;
    push_cmd(1'b0, 2'd2, 16'h0050, 16'h0000);
    tick(); tick(); tick();
    tests_run++; if (o_apb2dma_empty !== 1'b0) begin tests_failed++; $display("FAIL ab_prefill got empty=%b exp 0", o_apb2dma_empty); end
    i_pready = 4'b0111;
    push_cmd(1'b0, 2'd3, 16'h0077, 16'h0000);
    push_cmd(1'b1, 2'd0, 16'h0078, 16'h1111);
    push_cmd(1'b1, 2'd0, 16'h0079, 16'h2222);
    tests_run++; if (o_psel !== 4'b1000 || o_penable !== 1'b1) begin tests_failed++; $display("FAIL ab_inaccess got psel=%h en=%b exp psel=8 en=1", o_psel, o_penable); end
    nx0 = n_xfers;
    ns0 = n_setups;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    tests_run++; if (o_apb2dma_empty !== 1'b1 || o_dma2apb_full !== 1'b0) begin tests_failed++; $display("FAIL ab_flush got empty=%b full=%b exp 1 0", o_apb2dma_empty, o_dma2apb_full); end
    tests_run++; if (o_psel !== 4'b1000 || o_penable !== 1'b1) begin tests_failed++; $display("FAIL ab_continue got psel=%h en=%b exp psel=8 en=1", o_psel, o_penable); end
    tick(); tick();
    i_pready = 4'hF;
    for (int i = 0; i < 10; i++) tick();
    tests_run++; if (n_xfers - nx0 != 1) begin tests_failed++; $display("FAIL ab_complete got %0d exp 1", n_xfers - nx0); end
    tests_run++; if (n_setups != ns0) begin tests_failed++; $display("FAIL ab_no_issue got %0d setups exp 0", n_setups - ns0); end
    tests_run++; if (o_apb2dma_empty !== 1'b1 || o_psel !== 4'b0) begin tests_failed++; $display("FAIL ab_nopush got empty=%b psel=%h exp 1 0", o_apb2dma_empty, o_psel); end
  endtask

  task automatic test_backpressure();
    int n0, pops;
    n0 = n_xfers;
    pops = 0;
    i_pready = 4'hF;
    i_apb2dma_rready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 50 && o_dma2apb_full; k++) tick();
      push_cmd(1'b0, 2'd0, 16'h0100 + 16'(i), 16'h0000);
    end
    for (int i = 0; i < 20; i++) tick();
    tests_run++; if (n_xfers - n0 != 4) begin tests_failed++; $display("FAIL bp_reads got %0d exp 4", n_xfers - n0); end
    tests_run++; if (o_psel !== 4'b0 || o_apb2dma_empty !== 1'b0) begin tests_failed++; $display("FAIL bp_idle got psel=%h empty=%b exp 0 0", o_psel, o_apb2dma_empty); end
    i_apb2dma_rready = 1'b1;
    tick();
    i_apb2dma_rready = 1'b0;
    pops++;
    for (int i = 0; i < 10; i++) tick();
    tests_run++; if (n_xfers - n0 != 5) begin tests_failed++; $display("FAIL bp_resume got %0d exp 5", n_xfers - n0); end
    for (int i = 0; i < 60; i++) begin
      i_apb2dma_rready = 1'b1;
      if (!o_apb2dma_empty) pops++;
      tick();
    end
    i_apb2dma_rready = 1'b0;
    tests_run++; if (n_xfers - n0 != 6 || pops != 6) begin tests_failed++; $display("FAIL bp_drain got xfers=%0d pops=%0d exp 6 6", n_xfers - n0, pops); end
  endtask

  task automatic test_random();
    cmd_t        exp_cmd[$];
    logic [15:0] exp_rsp[$];
    cmd_t        c;
    logic [15:0] d;
    logic [3:0]  exp_psel;
    for (int cyc = 0; cyc < 900; cyc++) begin
      i_pready  = (cyc >= 700) ? 4'hF : 4'($urandom);
      i_prdata  = {$urandom, $urandom};
      i_pslverr = 4'b0;
      if (o_psel != 4'b0 && !o_penable) begin
        tests_run++;
        if (exp_cmd.size() == 0) begin
          tests_failed++; $display("FAIL rnd_spurious got psel=%h exp no transfer", o_psel);
        end else begin
          c = exp_cmd[0];
          exp_psel = 4'b0001 << c.sel;
          if (o_psel !== exp_psel || o_pwrite !== c.w || o_paddr !== c.addr || o_pwdata !== c.data) begin
            tests_failed++;
            $display("FAIL rnd_setup got psel=%h w=%b a=%h d=%h exp psel=%h w=%b a=%h d=%h",
                     o_psel, o_pwrite, o_paddr, o_pwdata, exp_psel, c.w, c.addr, c.data);
          end
        end
      end
      if (o_psel != 4'b0 && o_penable && (o_psel & i_pready) != 4'b0 && exp_cmd.size() > 0) begin
        c = exp_cmd.pop_front();
        if (!c.w) exp_rsp.push_back(i_prdata[c.sel*16 +: 16]);
      end
      i_apb2dma_rready = (cyc >= 720) ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (i_apb2dma_rready && !o_apb2dma_empty) begin
        tests_run++;
        if (exp_rsp.size() == 0) begin
          tests_failed++; $display("FAIL rnd_extra_rsp got %h exp none", o_apb_rdata);
        end else begin
          d = exp_rsp.pop_front();
          if (o_apb_rdata !== d) begin tests_failed++; $display("FAIL rnd_rdata got %h exp %h", o_apb_rdata, d); end
        end
      end
      i_dma2apb_wvalid = (cyc < 650) && ($urandom_range(0, 1) == 1);
      i_apb_pwrite = 1'($urandom);
      i_apb_psel   = 2'($urandom);
      i_apb_paddr  = 16'($urandom);
      i_apb_pdata  = 16'($urandom);
      if (i_dma2apb_wvalid && !o_dma2apb_full)
        exp_cmd.push_back('{w: i_apb_pwrite, sel: i_apb_psel, addr: i_apb_paddr, data: i_apb_pdata});
      tick();
    end
    i_dma2apb_wvalid = 1'b0;
    i_apb2dma_rready = 1'b0;
    i_pready = 4'hF;
    tests_run++; if (exp_cmd.size() != 0 || exp_rsp.size() != 0) begin tests_failed++; $display("FAIL rnd_leftover got cmds=%0d rsps=%0d exp 0 0", exp_cmd.size(), exp_rsp.size()); end
    tests_run++; if (o_apb2dma_empty !== 1'b1 || o_psel !== 4'b0) begin tests_failed++; $display("FAIL rnd_final got empty=%b psel=%h exp 1 0", o_apb2dma_empty, o_psel); end
  endtask

  task automatic test_reset_mid();
    i_pready = 4'b0;
    push_cmd(1'b1, 2'd1, 16'h0200, 16'h3333);
    tick(); tick();
    tests_run++; if (o_psel !== 4'b0010 || o_penable !== 1'b1) begin tests_failed++; $display("FAIL rm_access got psel=%h en=%b exp 2 1", o_psel, o_penable); end
    reset = 1'b1;
    #1;
    tests_run++; if (o_psel !== 4'b0 || o_penable !== 1'b0) begin tests_failed++; $display("FAIL rm_drop got psel=%h en=%b exp 0 0", o_psel, o_penable); end
    tick();
    reset = 1'b0;
    i_pready = 4'hF;
    tick(); tick();
    tests_run++; if (o_psel !== 4'b0 || o_paddr !== 16'h0 || o_apb2dma_empty !== 1'b1) begin tests_failed++; $display("FAIL rm_cleared got psel=%h a=%h empty=%b exp 0 0 1", o_psel, o_paddr, o_apb2dma_empty); end
  endtask

  initial begin
    reset = 1'b1;
    i_abort = 1'b0;
    i_dma2apb_wvalid = 1'b0;
    i_apb_pwrite = 1'b0;
    i_apb_psel = 2'd0;
    i_apb_paddr = 16'h0;
    i_apb_pdata = 16'h0;
    i_apb2dma_rready = 1'b0;
    i_pready = 4'hF;
    i_prdata = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    i_pslverr = 4'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_single_write();
    test_read_return();
    test_slverr();
    test_cmd_full();
    test_abort();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
